// File: rtl/mode_sequencer_pkg.sv
// mode_sequencer_pkg
// Shared mode encoding and segment animation patterns. Every block that
// decodes o_State imports this package so that all consumers agree on the
// encoding.
//   mode_e        : 2-bit display mode (INIT/AUTO/SWITCH/BIT)
//   SEG_A..SEG_F  : one-hot animation frames, bit 0 = segment A
//   anim_pattern  : animation index (0..5) to segment pattern
//   next_run_mode : long-press rotation AUTO -> SWITCH -> BIT -> AUTO
package mode_sequencer_pkg;

    typedef enum logic [1:0] {
        STATE_INIT   = 2'd0,
        STATE_AUTO   = 2'd1,
        STATE_SWITCH = 2'd2,
        STATE_BIT    = 2'd3
    } mode_e;

    localparam int unsigned ANIM_STEPS = 6;

    localparam logic [6:0] SEG_A = 7'h01;
    localparam logic [6:0] SEG_B = 7'h02;
    localparam logic [6:0] SEG_C = 7'h04;
    localparam logic [6:0] SEG_D = 7'h08;
    localparam logic [6:0] SEG_E = 7'h10;
    localparam logic [6:0] SEG_F = 7'h20;

    function automatic logic [6:0] anim_pattern(input logic [2:0] idx);
        logic [6:0] pat;
        case (idx)
            3'd0:    pat = SEG_A;
            3'd1:    pat = SEG_B;
            3'd2:    pat = SEG_C;
            3'd3:    pat = SEG_D;
            3'd4:    pat = SEG_E;
            3'd5:    pat = SEG_F;
            default: pat = SEG_A;
        endcase
        return pat;
    endfunction

    function automatic mode_e next_run_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            STATE_AUTO:   nxt = STATE_SWITCH;
            STATE_SWITCH: nxt = STATE_BIT;
            default:      nxt = STATE_AUTO;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mode_sequencer_press_timer.sv
// press_timer
// Saturating hold counter for one switch. Counts consecutive high samples,
// clears on a low sample or on i_Clear, and saturates at LONG_TICKS.
// o_Reached is a combinational one-shot, high only in the cycle whose
// sample would be the LONG_TICKS-th consecutive high one.
//   i_Clk      : system clock
//   i_Reset    : synchronous active-high reset
//   i_Sample   : switch level being timed
//   i_Clear    : forces the counter to zero and suppresses o_Reached
//   o_Reached  : long press completes on this clock edge
module press_timer #(
    parameter int unsigned LONG_TICKS = 25_000_000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Sample,
    input  logic i_Clear,
    output logic o_Reached
);

    localparam int unsigned CntW = $clog2(LONG_TICKS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(LONG_TICKS - 1);
    localparam logic [CntW-1:0] CntSat  = CntW'(LONG_TICKS);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        o_Reached = 1'b0;
        if (i_Clear || !i_Sample) begin
            cnt_d = '0;
        end else if (cnt_q != CntSat) begin
            cnt_d     = cnt_q + 1'b1;
            o_Reached = (cnt_q == CntLast);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer
// Selects the display mode for the single-digit 7-segment counter from the
// four debounced switches, and drives a rotating segment animation while
// in INIT. A long press of switch 4 rotates through the run modes.
// Optional build macro MODE_IDLE_TIMEOUT_EN adds an idle timeout that
// returns a run mode to INIT after IDLE_TICKS cycles with no switch activity.
//   i_Clk          : system clock, rising edge
//   i_Reset        : synchronous active-high reset
//   i_Switches     : debounced switch levels, bit 0 = switch 1
//   o_State        : current mode (mode_e encoding)
//   o_Segments     : animation pattern, bit 0 = A; zero outside INIT
//   o_Mode_Changed : one-cycle pulse after each mode change
//
// state        | meaning
// STATE_INIT   | animation running, waiting for any switch rising edge
// STATE_AUTO   | run mode, auto-count source
// STATE_SWITCH | run mode, switch nibble source
// STATE_BIT    | run mode, bit display source
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int unsigned ANIM_TICKS = 2_500_000,
    parameter int unsigned LONG_TICKS = 25_000_000,
    parameter int unsigned IDLE_TICKS = 250_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Switches,
    output logic [1:0] o_State,
    output logic [6:0] o_Segments,
    output logic       o_Mode_Changed
);

    localparam int unsigned AnimW = $clog2(ANIM_TICKS + 1);
    localparam logic [AnimW-1:0] AnimLast = AnimW'(ANIM_TICKS - 1);
    localparam logic [2:0] AnimIdxLast = 3'(ANIM_STEPS - 1);

    mode_e            state_q, state_d;
    logic [2:0]       anim_idx_q, anim_idx_d;
    logic [AnimW-1:0] anim_cnt_q, anim_cnt_d;
    logic [3:0]       sw_prev_q, sw_prev_d;
    logic [6:0]       seg_q, seg_d;
    logic             mode_chg_q, mode_chg_d;
    // Set when a switch press leaves INIT; keeps switch 4 from counting as a
    // long press until it has been released once.
    logic             wait_rel_q, wait_rel_d;

    logic             any_rise;
    logic             hold_clear;
    logic             long_reached;

`ifdef MODE_IDLE_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(IDLE_TICKS + 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TICKS - 1);
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
`else
    // IDLE_TICKS has no effect in this build.
    if (IDLE_TICKS == 0) begin : g_idle_ticks_unused
    end
`endif

    assign any_rise   = |(i_Switches & ~sw_prev_q);
    assign hold_clear = (state_q == STATE_INIT) || wait_rel_q;

    press_timer #(
        .LONG_TICKS (LONG_TICKS)
    ) u_press_timer (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .i_Sample  (i_Switches[3]),
        .i_Clear   (hold_clear),
        .o_Reached (long_reached)
    );

    always_comb begin
        state_d    = state_q;
        anim_idx_d = anim_idx_q;
        anim_cnt_d = anim_cnt_q;
        sw_prev_d  = i_Switches;
        wait_rel_d = wait_rel_q;
`ifdef MODE_IDLE_TIMEOUT_EN
        idle_cnt_d = '0;
`endif

        case (state_q)
            STATE_INIT: begin
                if (any_rise) begin
                    state_d    = STATE_AUTO;
                    wait_rel_d = 1'b1;
                end else if (anim_cnt_q == AnimLast) begin
                    anim_cnt_d = '0;
                    anim_idx_d = (anim_idx_q == AnimIdxLast) ? 3'd0 : anim_idx_q + 3'd1;
                end else begin
                    anim_cnt_d = anim_cnt_q + 1'b1;
                end
            end
            default: begin
                if (!i_Switches[3]) begin
                    wait_rel_d = 1'b0;
                end
                if (long_reached) begin
                    state_d = next_run_mode(state_q);
                end
`ifdef MODE_IDLE_TIMEOUT_EN
                // Long press has priority; its cycle has switch 4 high, so
                // the idle counter clears through the else branch anyway.
                else if ((i_Switches == 4'b0000) && !any_rise) begin
                    if (idle_cnt_q == IdleLast) begin
                        state_d = STATE_INIT;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end
        endcase

        // Animation restarts at A on every INIT entry and on an INIT exit.
        if (state_d != STATE_INIT) begin
            anim_idx_d = 3'd0;
            anim_cnt_d = '0;
        end

        seg_d      = (state_d == STATE_INIT) ? anim_pattern(anim_idx_d) : 7'b0;
        mode_chg_d = (state_d != state_q);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= STATE_INIT;
            anim_idx_q <= 3'd0;
            anim_cnt_q <= '0;
            sw_prev_q  <= 4'b1111;
            seg_q      <= SEG_A;
            mode_chg_q <= 1'b0;
            wait_rel_q <= 1'b0;
`ifdef MODE_IDLE_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            anim_idx_q <= anim_idx_d;
            anim_cnt_q <= anim_cnt_d;
            sw_prev_q  <= sw_prev_d;
            seg_q      <= seg_d;
            mode_chg_q <= mode_chg_d;
            wait_rel_q <= wait_rel_d;
`ifdef MODE_IDLE_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
`endif
        end
    end

    assign o_State        = state_q;
    assign o_Segments     = seg_q;
    assign o_Mode_Changed = mode_chg_q;

endmodule
